// File: rtl/control_sequencer_pkg.sv
// Shared ISA and control definitions: opcodes, IR field positions, FSM
// states and the datapath strobe bundle. The datapath/ALU decode imports
// the same package, so the IR layout is defined in one place.
package control_sequencer_pkg;

    typedef enum logic [4:0] {
        OP_LD   = 5'b00000,
        OP_ST   = 5'b00001,
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_AND  = 5'b00101,
        OP_OR   = 5'b00110,
        OP_NOP  = 5'b11010,
        OP_HALT = 5'b11011
    } opcode_e;

    typedef enum logic [2:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALTED, S_FAULT
    } state_e;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // One complete set of datapath/memory controls for a single cycle.
    typedef struct packed {
        logic pci, pco, iri, iro, mari, maro, mdri, mdro;
        logic ryi, rzi, rzo, r0i, r0o, r1i, r1o;
        logic mdr_sel, mem_rd, mem_wr;
    } ctrl_t;

    // Only r0 and r1 exist; any other register field value is illegal.
    function automatic logic reg_ok(input logic [3:0] field);
        return field[3:1] == 3'b000;
    endfunction

    // Drive the out-strobe of the register named by a (legal) field.
    function automatic ctrl_t drive_out(input ctrl_t c, input logic [3:0] field);
        ctrl_t r = c;
        if (field[0]) r.r1o = 1'b1;
        else          r.r0o = 1'b1;
        return r;
    endfunction

    // Drive the in-strobe of the register named by a (legal) field.
    function automatic ctrl_t drive_in(input ctrl_t c, input logic [3:0] field);
        ctrl_t r = c;
        if (field[0]) r.r1i = 1'b1;
        else          r.r0i = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath/memory connection: IR contents and memory ack in,
// register strobes and memory requests out.
interface control_sequencer_if;
    logic [31:0] ir;
    logic        mem_ack;
    logic        pci, pco, iri, iro, mari, maro, mdri, mdro;
    logic        ryi, rzi, rzo, r0i, r0o, r1i, r1o;
    logic        mdr_sel, mem_rd, mem_wr;

    modport master (
        input  ir, mem_ack,
        output pci, pco, iri, iro, mari, maro, mdri, mdro,
        output ryi, rzi, rzo, r0i, r0o, r1i, r1o,
        output mdr_sel, mem_rd, mem_wr
    );

    modport slave (
        output ir, mem_ack,
        input  pci, pco, iri, iro, mari, maro, mdri, mdro,
        input  ryi, rzi, rzo, r0i, r0o, r1i, r1o,
        input  mdr_sel, mem_rd, mem_wr
    );
endinterface

// File: rtl/control_sequencer_mem_wait_timer.sv
// Counts cycles spent waiting for mem_ack and flags a timeout in the cycle
// the count would reach MEM_TIMEOUT. MEM_TIMEOUT = 0 disables the timeout.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_i,
    input  logic ack_i,
    output logic timeout_o
);
    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    // Count only while waiting without ack; anything else (ack, leaving the
    // wait state) returns the counter to zero.
    always_comb begin
        count_d = '0;
        if (wait_i && !ack_i) count_d = count_q + 1'b1;
    end

    assign timeout_o = (MEM_TIMEOUT != 0) && wait_i && !ack_i && (count_q == LAST);

    // Wait counter register, synchronous active-low clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetches over the memory handshake,
// decodes IR[31:27] and issues one datapath strobe set per T-step.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus,
    output logic                halted,
    output logic                fault,
    output logic [31:0]         instr_count
);
    state_e      state_q, state_d;
    logic [31:0] instr_count_q, instr_count_d;
    ctrl_t       ctrl;
    logic        retire, in_wait, timeout, legal;
    opcode_e     op;
    logic [3:0]  ra, rb, rc;
    logic        unused_addr;

    assign op = opcode_e'(bus.ir[OP_MSB:OP_LSB]);
    assign ra = bus.ir[RA_MSB:RA_LSB];
    assign rb = bus.ir[RB_MSB:RB_LSB];
    assign rc = bus.ir[RC_MSB:RC_LSB];
    // Address bits are consumed by the datapath (iro), not by this block.
    assign unused_addr = ^bus.ir[RC_LSB-1:0];

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clock),
        .rst_n     (clear),
        .wait_i    (in_wait),
        .ack_i     (bus.mem_ack),
        .timeout_o (timeout)
    );

    // Opcode and register-field legality, judged at T3.
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: legal = reg_ok(ra) && reg_ok(rb) && reg_ok(rc);
            OP_LD, OP_ST:                  legal = reg_ok(ra);
            OP_NOP, OP_HALT:               legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
    end

    // Next state, strobe decode and retire detection for the current T-step.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        ctrl    = '0;
        retire  = 1'b0;
        in_wait = 1'b0;
        case (state_q)
            S_T0: begin
                ctrl.pco = 1'b1; ctrl.mari = 1'b1; ctrl.pci = 1'b1;
                state_d  = S_T1;
            end
            S_T1: begin
                ctrl.mem_rd = 1'b1;
                in_wait     = 1'b1;
                if (bus.mem_ack) begin
                    ctrl.mdri = 1'b1;
                    state_d   = S_T2;
                end else if (timeout) state_d = S_FAULT;
            end
            S_T2: begin
                ctrl.mdro = 1'b1; ctrl.iri = 1'b1;
                state_d   = S_T3;
            end
            S_T3: begin
                if (!legal) state_d = S_FAULT;
                else begin
                    case (op)
                        OP_LD, OP_ST: begin
                            ctrl.iro = 1'b1; ctrl.mari = 1'b1;
                            state_d  = S_T4;
                        end
                        OP_NOP:  begin retire = 1'b1; state_d = S_T0;     end
                        OP_HALT: begin retire = 1'b1; state_d = S_HALTED; end
                        default: begin
                            ctrl     = drive_out(ctrl, rb);
                            ctrl.ryi = 1'b1;
                            state_d  = S_T4;
                        end
                    endcase
                end
            end
            S_T4: begin
                case (op)
                    OP_LD: begin
                        ctrl.mem_rd = 1'b1;
                        in_wait     = 1'b1;
                        if (bus.mem_ack) begin
                            ctrl.mdri = 1'b1;
                            state_d   = S_T5;
                        end else if (timeout) state_d = S_FAULT;
                    end
                    OP_ST: begin
                        ctrl         = drive_out(ctrl, ra);
                        ctrl.mdri    = 1'b1;
                        ctrl.mdr_sel = 1'b1;
                        state_d      = S_T5;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ctrl     = drive_out(ctrl, rc);
                        ctrl.rzi = 1'b1;
                        state_d  = S_T5;
                    end
                    default: state_d = S_FAULT;
                endcase
            end
            S_T5: begin
                case (op)
                    OP_LD: begin
                        ctrl      = drive_in(ctrl, ra);
                        ctrl.mdro = 1'b1;
                        retire    = 1'b1;
                        state_d   = S_T0;
                    end
                    OP_ST: begin
                        ctrl.mem_wr = 1'b1;
                        in_wait     = 1'b1;
                        if (bus.mem_ack) begin
                            retire  = 1'b1;
                            state_d = S_T0;
                        end else if (timeout) state_d = S_FAULT;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ctrl     = drive_in(ctrl, ra);
                        ctrl.rzo = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_T0;
                    end
                    default: state_d = S_FAULT;
                endcase
            end
            default: state_d = state_q;  // HALTED and FAULT are terminal
        endcase
        if (!clear) ctrl = '0;
    end

    // Retired-instruction counter, wrapping at 2^32.
    always_comb begin
        instr_count_d = retire ? instr_count_q + 32'd1 : instr_count_q;
    end

    // State and counter registers; clear aborts any instruction in flight.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q       <= S_T0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign halted      = (state_q == S_HALTED);
    assign fault       = (state_q == S_FAULT);
    assign instr_count = instr_count_q;

    assign bus.pci     = ctrl.pci;
    assign bus.pco     = ctrl.pco;
    assign bus.iri     = ctrl.iri;
    assign bus.iro     = ctrl.iro;
    assign bus.mari    = ctrl.mari;
    assign bus.maro    = ctrl.maro;
    assign bus.mdri    = ctrl.mdri;
    assign bus.mdro    = ctrl.mdro;
    assign bus.ryi     = ctrl.ryi;
    assign bus.rzi     = ctrl.rzi;
    assign bus.rzo     = ctrl.rzo;
    assign bus.r0i     = ctrl.r0i;
    assign bus.r0o     = ctrl.r0o;
    assign bus.r1i     = ctrl.r1i;
    assign bus.r1o     = ctrl.r1o;
    assign bus.mdr_sel = ctrl.mdr_sel;
    assign bus.mem_rd  = ctrl.mem_rd;
    assign bus.mem_wr  = ctrl.mem_wr;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. A per-instruction trace model builds
// the expected strobe set, count and sticky flags for every cycle; one
// compare process checks them on the falling edge.
module tb_control_sequencer;

    localparam int TIMEOUT = 15;

    // Strobe bit masks, ordered as the sampled vector below.
    localparam logic [17:0] PCI     = 18'h20000;
    localparam logic [17:0] PCO     = 18'h10000;
    localparam logic [17:0] IRI     = 18'h08000;
    localparam logic [17:0] IRO     = 18'h04000;
    localparam logic [17:0] MARI    = 18'h02000;
    localparam logic [17:0] MDRI    = 18'h00800;
    localparam logic [17:0] MDRO    = 18'h00400;
    localparam logic [17:0] RYI     = 18'h00200;
    localparam logic [17:0] RZI     = 18'h00100;
    localparam logic [17:0] RZO     = 18'h00080;
    localparam logic [17:0] R0I     = 18'h00040;
    localparam logic [17:0] R0O     = 18'h00020;
    localparam logic [17:0] R1I     = 18'h00010;
    localparam logic [17:0] R1O     = 18'h00008;
    localparam logic [17:0] MDR_SEL = 18'h00004;
    localparam logic [17:0] MEM_RD  = 18'h00002;
    localparam logic [17:0] MEM_WR  = 18'h00001;
    localparam logic [17:0] NONE    = 18'h00000;

    logic        clock;
    logic        clear;
    logic        halted, fault;
    logic [31:0] instr_count;

    control_sequencer_if tb_if ();

    control_sequencer dut (
        .clock       (clock),
        .clear       (clear),
        .bus         (tb_if),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 1'b0;
    bit          preload  = 1'b0;
    logic [17:0] exp_vec;
    logic [31:0] exp_cnt;
    logic        exp_halt, exp_fault;
    string       exp_tag;
    logic [17:0] act_vec;

    // Model state: what the sequencer must show from the rules alone.
    logic [31:0] m_count;
    logic        m_halt, m_fault;

    // The one compare process.
    always @(negedge clock) begin
        if (chk_en) begin
            act_vec = {tb_if.pci, tb_if.pco, tb_if.iri, tb_if.iro, tb_if.mari, tb_if.maro,
                       tb_if.mdri, tb_if.mdro, tb_if.ryi, tb_if.rzi, tb_if.rzo,
                       tb_if.r0i, tb_if.r0o, tb_if.r1i, tb_if.r1o,
                       tb_if.mdr_sel, tb_if.mem_rd, tb_if.mem_wr};
            n_checks += 4;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL %s strobes actual=%b required=%b", exp_tag, act_vec, exp_vec);
            end
            if (instr_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL %s instr_count actual=%h required=%h", exp_tag, instr_count, exp_cnt);
            end
            if (halted !== exp_halt) begin
                n_fail++;
                $display("FAIL %s halted actual=%b required=%b", exp_tag, halted, exp_halt);
            end
            if (fault !== exp_fault) begin
                n_fail++;
                $display("FAIL %s fault actual=%b required=%b", exp_tag, fault, exp_fault);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive mem_ack, publish the expectation, advance.
    task automatic cyc(input logic ack, input logic [17:0] v, input string tag);
        tb_if.mem_ack = ack;
        exp_vec   = v;
        exp_cnt   = m_count;
        exp_halt  = m_halt;
        exp_fault = m_fault;
        exp_tag   = tag;
        chk_en    = 1'b1;
        @(posedge clock);
        #1;
        tb_if.mem_ack = 1'b0;
        if (preload) begin
            release dut.instr_count_d;
            m_count = 32'hFFFF_FFFF;
            preload = 1'b0;
        end
    endtask

    function automatic logic [17:0] r_out(input logic [3:0] f);
        return f[0] ? R1O : R0O;
    endfunction

    function automatic logic [17:0] r_in(input logic [3:0] f);
        return f[0] ? R1I : R0I;
    endfunction

    function automatic bit legal(input logic [4:0] op, input logic [3:0] ra,
                                 input logic [3:0] rb, input logic [3:0] rc);
        if (op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110}) return ra < 2 && rb < 2 && rc < 2;
        if (op inside {5'b00000, 5'b00001})                     return ra < 2;
        return op inside {5'b11010, 5'b11011};
    endfunction

    // A memory wait: ack arrives after w idle cycles (w < 0 means never).
    // Without ack the sequencer holds the request for TIMEOUT cycles, then faults.
    task automatic mem_phase(input logic [17:0] base, input logic [17:0] on_ack,
                             input int w, input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (i == w) begin
                cyc(1'b1, base | on_ack, tag);
                ok = 1'b1;
                break;
            end
            cyc(1'b0, base, tag);
        end
        if (!ok) m_fault = 1'b1;
    endtask

    // Run one instruction end to end against the model trace.
    task automatic exec(input logic [31:0] instr, input int w1, input int w2);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit         ok;
        op = instr[31:27];
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        tb_if.ir = instr;
        cyc(1'b0, PCO | MARI | PCI, "T0");
        mem_phase(MEM_RD, MDRI, w1, "T1", ok);
        if (!ok) return;
        cyc(1'b0, MDRO | IRI, "T2");
        if (!legal(op, ra, rb, rc)) begin
            cyc(1'b0, NONE, "T3_illegal");
            m_fault = 1'b1;
            return;
        end
        case (op)
            5'b11010: begin
                cyc(1'b0, NONE, "T3_nop");
                m_count++;
            end
            5'b11011: begin
                cyc(1'b0, NONE, "T3_halt");
                m_count++;
                m_halt = 1'b1;
            end
            5'b00000: begin
                cyc(1'b0, IRO | MARI, "T3_ld");
                mem_phase(MEM_RD, MDRI, w2, "T4_ld", ok);
                if (ok) begin
                    cyc(1'b0, MDRO | r_in(ra), "T5_ld");
                    m_count++;
                end
            end
            5'b00001: begin
                cyc(1'b0, IRO | MARI, "T3_st");
                cyc(1'b0, r_out(ra) | MDRI | MDR_SEL, "T4_st");
                mem_phase(MEM_WR, NONE, w2, "T5_st", ok);
                if (ok) m_count++;
            end
            default: begin
                cyc(1'b0, r_out(rb) | RYI, "T3_alu");
                cyc(1'b0, r_out(rc) | RZI, "T4_alu");
                cyc(1'b0, RZO | r_in(ra), "T5_alu");
                m_count++;
            end
        endcase
    endtask

    // Terminal-state idling with mem_ack toggling: nothing may move.
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(i[0], NONE, tag);
    endtask

    task automatic do_reset();
        clear = 1'b0;
        cyc(1'b0, NONE, "rst_enter");
        m_count = '0;
        m_halt  = 1'b0;
        m_fault = 1'b0;
        cyc(1'b1, NONE, "rst_hold");
        clear = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear         = 1'b0;
        tb_if.ir      = '0;
        tb_if.mem_ack = 1'b0;
        m_count       = '0;
        m_halt        = 1'b0;
        m_fault       = 1'b0;
        @(posedge clock);
        #1;
        cyc(1'b0, NONE, "rst_hold");
        clear = 1'b1;
        check("reset_count", instr_count, 32'd0);
        check("reset_flags", {30'd0, halted, fault}, 32'd0);

        // ADD r0 = r1 + r0, ack in first T1 cycle.
        exec(32'h1808_0000, 0, 0);
        check("add_count", instr_count, 32'd1);
        // LD r1, 0x00040 with 3 wait cycles in T1 and in T4.
        exec(32'h0080_0040, 3, 3);
        check("ld_count", instr_count, 32'd2);
        // SUB r1 = r0 - r1.
        exec(32'h2080_8000, 1, 0);
        // ST r0 -> 0x10 with acks after 1 and 2 waits.
        exec(32'h0800_0010, 1, 2);
        // AND r1 = r1 & r1, then NOP.
        exec(32'h2888_8000, 0, 0);
        exec(32'hD000_0000, 2, 0);
        check("mix_count", instr_count, 32'd6);

        // Clear during LD T4 with a same-edge ack: clear wins, no retire.
        tb_if.ir = 32'h0080_0040;
        cyc(1'b0, PCO | MARI | PCI, "ab_T0");
        cyc(1'b1, MEM_RD | MDRI, "ab_T1");
        cyc(1'b0, MDRO | IRI, "ab_T2");
        cyc(1'b0, IRO | MARI, "ab_T3");
        cyc(1'b0, MEM_RD, "ab_T4");
        clear = 1'b0;
        cyc(1'b1, NONE, "ab_clear");
        clear   = 1'b1;
        m_count = '0;
        check("abort_count", instr_count, 32'd0);
        exec(32'hD000_0000, 0, 0);
        check("after_abort_count", instr_count, 32'd1);

        // Count wrap: preload 2^32-1 during a NOP's T0, retire gives 0.
        force dut.instr_count_d = 32'hFFFF_FFFF;
        preload = 1'b1;
        exec(32'hD000_0000, 0, 0);
        check("wrap_count", instr_count, 32'd0);

        // Illegal opcode 00010 -> fault at T3, count unchanged.
        exec(32'h1000_0000, 0, 0);
        check("bad_op_fault", {31'd0, fault}, 32'd1);
        check("bad_op_count", instr_count, 32'd0);
        idle(4, "fault_idle");
        do_reset();

        // ADD with Ra = 2 -> fault at T3.
        exec(32'h1908_0000, 0, 0);
        check("bad_reg_fault", {31'd0, fault}, 32'd1);
        idle(3, "fault_idle");
        do_reset();

        // ST with no ack: mem_wr for exactly TIMEOUT cycles, then fault.
        exec(32'h0800_0010, 0, -1);
        check("st_timeout_fault", {31'd0, fault}, 32'd1);
        idle(4, "timeout_idle");
        do_reset();

        // Fetch with no ack also times out.
        exec(32'hD000_0000, -1, 0);
        idle(2, "fetch_timeout_idle");
        do_reset();

        // HALT: sticky halted, count+1, acks ignored afterwards.
        exec(32'h1808_0000, 0, 0);
        exec(32'hD800_0000, 0, 0);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_count", instr_count, 32'd2);
        idle(6, "halted_idle");
        do_reset();
        check("final_reset_count", instr_count, 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
